// File: rtl/cv_ctrl_pkg.sv
// Shared definitions for the ColecoVision controller-port engine: key codes,
// button vector layout and the quadrature Gray-step helper.
package cv_ctrl_pkg;

    localparam logic [3:0] CV_KEY_0      = 4'b0011;
    localparam logic [3:0] CV_KEY_1      = 4'b1110;
    localparam logic [3:0] CV_KEY_2      = 4'b1101;
    localparam logic [3:0] CV_KEY_3      = 4'b0110;
    localparam logic [3:0] CV_KEY_4      = 4'b0001;
    localparam logic [3:0] CV_KEY_5      = 4'b1001;
    localparam logic [3:0] CV_KEY_6      = 4'b0111;
    localparam logic [3:0] CV_KEY_7      = 4'b1100;
    localparam logic [3:0] CV_KEY_8      = 4'b1000;
    localparam logic [3:0] CV_KEY_9      = 4'b1011;
    localparam logic [3:0] CV_KEY_STAR   = 4'b1010;
    localparam logic [3:0] CV_KEY_HASH   = 4'b0101;
    localparam logic [3:0] CV_KEY_PURPLE = 4'b0100;
    localparam logic [3:0] CV_KEY_BLUE   = 4'b0010;
    localparam logic [3:0] CV_KEY_NONE   = 4'b1111;

    localparam int BTN_W = 20;
    typedef logic [BTN_W-1:0] ctrl_btn_t;

    localparam int BTN_R      = 0;
    localparam int BTN_L      = 1;
    localparam int BTN_D      = 2;
    localparam int BTN_U      = 3;
    localparam int BTN_FIRE1  = 4;
    localparam int BTN_FIRE2  = 5;
    localparam int BTN_KEY0   = 6;
    localparam int BTN_KEYS_N = 12;
    localparam int BTN_PURPLE = 18;
    localparam int BTN_BLUE   = 19;

    // Entry i is the code for button bit BTN_KEY0+i; lower i wins priority.
    localparam logic [13:0][3:0] KEY_CODES = {
        CV_KEY_BLUE, CV_KEY_PURPLE, CV_KEY_HASH, CV_KEY_STAR,
        CV_KEY_9, CV_KEY_8, CV_KEY_7, CV_KEY_6, CV_KEY_5,
        CV_KEY_4, CV_KEY_3, CV_KEY_2, CV_KEY_1, CV_KEY_0
    };

    localparam logic [1:0] PHASE_RESET = 2'b11;

    function automatic logic [1:0] gray_step(input logic [1:0] phase, input logic fwd);
        logic [1:0] nxt;
        case (phase)
            2'b00:   nxt = fwd ? 2'b01 : 2'b10;
            2'b01:   nxt = fwd ? 2'b11 : 2'b00;
            2'b11:   nxt = fwd ? 2'b10 : 2'b01;
            default: nxt = fwd ? 2'b00 : 2'b11;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cv_ctrl_debounce.sv
// Per-bit debounce: a bit's filtered value follows raw only after raw has
// differed from it for DEB_TICKS consecutive ce ticks.
module cv_ctrl_debounce #(
    parameter int WIDTH     = 20,
    parameter int DEB_TICKS = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] filt
);

    localparam logic [7:0] LAST = 8'(DEB_TICKS - 1);

    logic [7:0] cnt [WIDTH];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (raw[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    filt[i] <= raw[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cv_ctrl_mux.sv
// ColecoVision controller-port engine: debounced buttons, registered keypad
// encoder and quadrature spinner per port. Optional turbo fire: CV_CTRL_TURBO_EN.
module cv_ctrl_mux
    import cv_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEB_TICKS = 8,
    parameter int ACC_W     = 10,
    parameter int STEP_DIV  = 64,
    parameter int TURBO_DIV = 16384
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce,
    input  logic [NUM_PORTS-1:0][31:0] joy_i,
    input  logic [NUM_PORTS-1:0][8:0]  spin_i,
    input  logic [NUM_PORTS-1:0]       ctrl_p5_i,
    input  logic [NUM_PORTS-1:0]       ctrl_p8_i,
`ifdef CV_CTRL_TURBO_EN
    input  logic [NUM_PORTS-1:0]       turbo_en_i,
`endif
    output logic [NUM_PORTS-1:0][3:0]  ctrl_p14_o,
    output logic [NUM_PORTS-1:0]       ctrl_p6_o,
    output logic [NUM_PORTS-1:0]       ctrl_p7_o,
    output logic [NUM_PORTS-1:0]       ctrl_p9_o
);

    localparam int SDIV_W = $clog2(STEP_DIV);
    // Headroom so acc + delta - 1 never wraps before saturation.
    localparam int SUM_W  = ((ACC_W > 8) ? ACC_W : 8) + 2;
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] lim;
        lim = v;
        if (v > ACC_MAX) begin
            lim = ACC_MAX;
        end else if (v < -ACC_MAX) begin
            lim = -ACC_MAX;
        end
        return lim[ACC_W-1:0];
    endfunction

    function automatic logic [3:0] keypad_encode(input ctrl_btn_t b);
        logic [3:0] code;
        code = CV_KEY_NONE;
        for (int i = BTN_BLUE; i >= BTN_KEY0; i--) begin
            if (b[5'(i)]) begin
                code = KEY_CODES[4'(i - BTN_KEY0)];
            end
        end
        return code;
    endfunction

    logic [SDIV_W-1:0] step_cnt;
    logic              step_tick;

    assign step_tick = ce && (step_cnt == SDIV_W'(STEP_DIV - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (ce) begin
            step_cnt <= step_tick ? '0 : step_cnt + SDIV_W'(1);
        end
    end

`ifdef CV_CTRL_TURBO_EN
    localparam int TDIV_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TDIV_W-1:0] turbo_cnt;
    logic              wave;

    // Wave starts high so a fresh press fires immediately.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            turbo_cnt <= '0;
            wave      <= 1'b1;
        end else if (ce) begin
            if (turbo_cnt == TDIV_W'(TURBO_DIV - 1)) begin
                turbo_cnt <= '0;
                wave      <= ~wave;
            end else begin
                turbo_cnt <= turbo_cnt + TDIV_W'(1);
            end
        end
    end
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ctrl_btn_t filt;
        logic      unused_joy_hi;
        logic      fire1_eff;
        logic [3:0] p14_r;
        logic       p6_r;

        assign unused_joy_hi = ^joy_i[p][31:BTN_W];

        cv_ctrl_debounce #(
            .WIDTH     (BTN_W),
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk_sys (clk_sys),
            .reset   (reset),
            .ce      (ce),
            .raw     (joy_i[p][BTN_W-1:0]),
            .filt    (filt)
        );

`ifdef CV_CTRL_TURBO_EN
        assign fire1_eff = filt[BTN_FIRE1] & (~turbo_en_i[p] | wave);
`else
        assign fire1_eff = filt[BTN_FIRE1];
`endif

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                p14_r <= CV_KEY_NONE;
                p6_r  <= 1'b1;
            end else begin
                p14_r <= (ctrl_p5_i[p] ? CV_KEY_NONE : keypad_encode(filt))
                       & (ctrl_p8_i[p] ? CV_KEY_NONE
                                       : ~{filt[BTN_U], filt[BTN_D], filt[BTN_L], filt[BTN_R]});
                p6_r  <= (ctrl_p5_i[p] | ~filt[BTN_FIRE2]) & (ctrl_p8_i[p] | ~fire1_eff);
            end
        end

        assign ctrl_p14_o[p] = p14_r;
        assign ctrl_p6_o[p]  = p6_r;

        logic signed [ACC_W-1:0] acc;
        logic [1:0]              phase;
        logic                    last_tog;
        logic                    fresh;
        logic                    stepping;
        logic signed [SUM_W-1:0] acc_x;
        logic signed [SUM_W-1:0] delta_x;
        logic signed [SUM_W-1:0] step_adj;
        logic signed [SUM_W-1:0] sum;

        assign fresh = spin_i[p][8] != last_tog;

        // A delta and a step in the same tick combine before saturation.
        always_comb begin
            stepping = step_tick && (acc != '0);
            acc_x    = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
            delta_x  = '0;
            if (fresh) begin
                delta_x = {{(SUM_W-8){spin_i[p][7]}}, spin_i[p][7:0]};
            end
            step_adj = '0;
            if (stepping) begin
                step_adj = acc[ACC_W-1] ? '1 : SUM_W'(1);
            end
            sum = acc_x + delta_x - step_adj;
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                acc      <= '0;
                phase    <= PHASE_RESET;
                last_tog <= spin_i[p][8];
            end else if (ce) begin
                if (fresh) begin
                    last_tog <= spin_i[p][8];
                end
                acc <= sat_acc(sum);
                if (stepping) begin
                    phase <= gray_step(phase, ~acc[ACC_W-1]);
                end
            end
        end

        assign ctrl_p7_o[p] = phase[0];
        assign ctrl_p9_o[p] = phase[1];
    end

endmodule

// File: tb/tb_cv_ctrl_mux.sv
// Scoreboard bench for cv_ctrl_mux: a behavioural model predicts every cycle's
// port outputs, a monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_cv_ctrl_mux;

    localparam int NP      = 4;
    localparam int DEB     = 8;
    localparam int ACCW    = 6;
    localparam int SDIV    = 4;
    localparam int TDIV    = 4;
    localparam int ACC_LIM = (1 << (ACCW - 1)) - 1;
    localparam int NCYC    = 6000;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic                 ce;
    logic [NP-1:0][31:0]  joy_i;
    logic [NP-1:0][8:0]   spin_i;
    logic [NP-1:0]        ctrl_p5_i;
    logic [NP-1:0]        ctrl_p8_i;
`ifdef CV_CTRL_TURBO_EN
    logic [NP-1:0]        turbo_en_i;
`endif
    logic [NP-1:0][3:0]   ctrl_p14_o;
    logic [NP-1:0]        ctrl_p6_o;
    logic [NP-1:0]        ctrl_p7_o;
    logic [NP-1:0]        ctrl_p9_o;

    always #5 clk_sys = ~clk_sys;

    cv_ctrl_mux #(
        .NUM_PORTS (NP),
        .DEB_TICKS (DEB),
        .ACC_W     (ACCW),
        .STEP_DIV  (SDIV),
        .TURBO_DIV (TDIV)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce         (ce),
        .joy_i      (joy_i),
        .spin_i     (spin_i),
        .ctrl_p5_i  (ctrl_p5_i),
        .ctrl_p8_i  (ctrl_p8_i),
`ifdef CV_CTRL_TURBO_EN
        .turbo_en_i (turbo_en_i),
`endif
        .ctrl_p14_o (ctrl_p14_o),
        .ctrl_p6_o  (ctrl_p6_o),
        .ctrl_p7_o  (ctrl_p7_o),
        .ctrl_p9_o  (ctrl_p9_o)
    );

    typedef struct packed {
        logic [NP-1:0][3:0] p14;
        logic [NP-1:0]      p6;
        logic [NP-1:0]      p7;
        logic [NP-1:0]      p9;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Keypad codes in priority order: 0..9, *, #, purple, blue.
    logic [3:0] key_tab [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001,
                                 4'b1001, 4'b0111, 4'b1100, 4'b1000, 4'b1011,
                                 4'b1010, 4'b0101, 4'b0100, 4'b0010};
    // Forward quadrature sequence; reset phase 11 is position 2.
    logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic [19:0] filt_m [NP];
    int          run_m  [NP][20];
    int          acc_m  [NP];
    int          pos_m  [NP];
    logic        last_m [NP];
    int          ticks;
    int          hold   [NP];

    task automatic model_edge();
        exp_t       e;
        logic [3:0] kp;
        logic [3:0] js;
        logic       f1;
        logic       fresh;
        logic       stp;
        logic [1:0] ph;
        int         d;
        int         nxt;
        e = '0;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                filt_m[p] = '0;
                for (int b = 0; b < 20; b++) run_m[p][b] = 0;
                acc_m[p]  = 0;
                pos_m[p]  = 2;
                last_m[p] = spin_i[p][8];
                e.p14[p]  = 4'hF;
                e.p6[p]   = 1'b1;
            end
            ticks = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                kp = 4'hF;
                if (!ctrl_p5_i[p]) begin
                    for (int k = 0; k < 14; k++) begin
                        if (filt_m[p][6+k]) begin
                            kp = key_tab[k];
                            break;
                        end
                    end
                end
                js = ctrl_p8_i[p] ? 4'hF : ~{filt_m[p][3], filt_m[p][2], filt_m[p][1], filt_m[p][0]};
                f1 = filt_m[p][4];
`ifdef CV_CTRL_TURBO_EN
                if (turbo_en_i[p] && ((ticks / TDIV) % 2 == 1)) f1 = 1'b0;
`endif
                e.p14[p] = kp & js;
                e.p6[p]  = (ctrl_p5_i[p] || !filt_m[p][5]) && (ctrl_p8_i[p] || !f1);
            end
            if (ce) begin
                for (int p = 0; p < NP; p++) begin
                    for (int b = 0; b < 20; b++) begin
                        if (joy_i[p][b] != filt_m[p][b]) begin
                            run_m[p][b]++;
                            if (run_m[p][b] == DEB) begin
                                filt_m[p][b] = joy_i[p][b];
                                run_m[p][b]  = 0;
                            end
                        end else begin
                            run_m[p][b] = 0;
                        end
                    end
                    fresh = spin_i[p][8] != last_m[p];
                    d     = fresh ? int'($signed(spin_i[p][7:0])) : 0;
                    stp   = (ticks % SDIV == SDIV - 1) && (acc_m[p] != 0);
                    nxt   = acc_m[p] + d - (stp ? ((acc_m[p] > 0) ? 1 : -1) : 0);
                    if (nxt > ACC_LIM)  nxt = ACC_LIM;
                    if (nxt < -ACC_LIM) nxt = -ACC_LIM;
                    if (stp) pos_m[p] = (pos_m[p] + ((acc_m[p] > 0) ? 1 : 3)) % 4;
                    acc_m[p] = nxt;
                    if (fresh) last_m[p] = spin_i[p][8];
                end
                ticks++;
            end
        end
        for (int p = 0; p < NP; p++) begin
            ph = gray_seq[pos_m[p]];
            e.p7[p] = ph[0];
            e.p9[p] = ph[1];
        end
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk_sys);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got.p14 = ctrl_p14_o;
                got.p6  = ctrl_p6_o;
                got.p7  = ctrl_p7_o;
                got.p9  = ctrl_p9_o;
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    if (miscompares <= 20)
                        $display("FAIL outputs @%0t: got p14=%h p6=%b p7=%b p9=%b, want p14=%h p6=%b p7=%b p9=%b",
                                 $time, got.p14, got.p6, got.p7, got.p9, e.p14, e.p6, e.p7, e.p9);
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        reset     = 1'b1;
        ce        = 1'b1;
        joy_i     = '0;
        spin_i    = '0;
        ctrl_p5_i = '1;
        ctrl_p8_i = '1;
`ifdef CV_CTRL_TURBO_EN
        turbo_en_i = '0;
`endif
        for (int p = 0; p < NP; p++) hold[p] = 0;

        // Three reset cycles with spinner toggles that must not count.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_sys); #1;
            model_edge();
            if (c < 2) begin
                for (int p = 0; p < NP; p++) spin_i[p] = {~spin_i[p][8], 8'($urandom)};
            end else begin
                reset = 1'b0;
            end
        end

        // Saturating burst on port 0, then a quiet drain period.
        for (int c = 0; c < 3; c++) begin
            spin_i[0] = {~spin_i[0][8], 8'd127};
            @(posedge clk_sys); #1;
            model_edge();
        end
        repeat (150) begin
            @(posedge clk_sys); #1;
            model_edge();
        end

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk_sys); #1;
            model_edge();
            reset = ($urandom_range(0, 999) == 0);
            ce    = ((c % 2000) < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) begin
                if (hold[p] == 0) begin
                    w = $urandom;
                    for (int b = 0; b < 20; b++) w[b] = ($urandom_range(0, 5) == 0);
                    joy_i[p] = w;
                    hold[p]  = $urandom_range(1, 20);
                end else begin
                    hold[p]--;
                end
                ctrl_p5_i[p] = 1'($urandom_range(0, 1));
                ctrl_p8_i[p] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 31) == 0)
                    spin_i[p] = {~spin_i[p][8],
                                 ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 8) - 4)};
`ifdef CV_CTRL_TURBO_EN
                if ($urandom_range(0, 199) == 0) turbo_en_i[p] = ~turbo_en_i[p];
`endif
            end
        end

        reset = 1'b0;
        @(posedge clk_sys); #1;
        model_edge();
        @(negedge clk_sys); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
